mips_dbg_ctrl: RTL and testbench
================================

MIPS_DBG_CTRL -- requirements
Module: mips_dbg_ctrl

Interface
REQ-001 Parameter: CNT_W, 32, width of the run-cycle counter and cmd_arg.
REQ-002 Parameter: NREGS, 32, number of register-file entries read out by DUMP.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_op  in  2  00 RUN, 01 STEP, 10 DUMP, 11 SET_BP.
REQ-008 cmd_arg  in  CNT_W  cycle count for RUN; breakpoint PC for SET_BP.
REQ-009 halt_req  in  1  single-cycle request to stop an active run.
REQ-010 cpu_run  out  1  CPU datapath enable; PC and register file advance only when high.
REQ-011 cpu_pc  in  32  current CPU program counter.
REQ-012 rf_raddr  out  5  register-file read address (combinational read).
REQ-013 rf_rdata  in  32  register-file read data.
REQ-014 dump_valid / dump_ready  out / in  1 / 1  register-dump handshake.
REQ-015 dump_idx  out  5  index of the register in dump_data.
REQ-016 dump_data  out  32  register value.
REQ-017 halted  out  1  high whenever state is IDLE.
REQ-018 stop_cause  out  2  00 NONE, 01 COUNT, 10 BP, 11 HALT.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DUMP_LD, DUMP_HS; cmd_ready SHALL equal (state==IDLE).
REQ-020 RUN with cmd_arg=N>0: load counter=N, enter RUN; cpu_run=1 for exactly N consecutive cycles, then IDLE with stop_cause=COUNT.
REQ-021 RUN with cmd_arg=0: SHALL remain IDLE, cpu_run stays 0, stop_cause=COUNT.
REQ-022 STEP: identical to RUN with N=1, cmd_arg ignored.
REQ-023 halt_req in RUN: cpu_run=0 in that same cycle, next state IDLE, stop_cause=HALT; halt_req SHALL be ignored in all other states.
REQ-024 Stop priority in one cycle: HALT > BP > COUNT.
REQ-025 DUMP: enter DUMP_LD with idx=0; DUMP_LD drives rf_raddr=idx and registers rf_rdata into dump_data; DUMP_HS holds dump_valid=1 with stable dump_idx/dump_data until dump_ready.
REQ-026 On a DUMP_HS handshake: if idx==NREGS-1, go IDLE (stop_cause unchanged); else idx+1, back to DUMP_LD.
REQ-027 First dump_valid SHALL assert 2 cycles after DUMP acceptance; cpu_run SHALL be 0 throughout DUMP.
REQ-028 cpu_run SHALL be 0 in IDLE, DUMP_LD and DUMP_HS.

Reset
REQ-029 On rst: state IDLE, cpu_run 0, counter 0, idx 0, dump_valid 0, dump_data 0, stop_cause NONE, bp_armed 0, bp_addr 0.
REQ-030 rst asserted mid-RUN or mid-DUMP SHALL drop cpu_run/dump_valid on the next edge with no further CPU cycle or handshake.

Configuration
REQ-031 Macro MIPS_DBG_BREAKPOINT_EN.
REQ-032 Defined: SET_BP loads bp_addr=cmd_arg[31:0], sets bp_armed, completes in 1 cycle, stop_cause unchanged.
REQ-033 Defined: in RUN, if bp_armed && cpu_pc==bp_addr and not the first RUN cycle, cpu_run=0 that cycle, go IDLE, stop_cause=BP; the first-cycle exemption lets a run resume from the breakpoint.
REQ-034 Undefined: no bp registers; SET_BP accepted as a 1-cycle no-op; stop_cause never BP.

Structure
REQ-035 Package mips_dbg_pkg SHALL hold the state enum, cmd_op codes and stop_cause codes.
REQ-036 Register readout SHALL be sub-module mips_dbg_dump_seq (idx counter, DUMP_LD/DUMP_HS handshake); top owns RUN logic and breakpoint.

Verification
REQ-037 RUN arg=5 from PC=0 -> cpu_run high 5 cycles, halted back, stop_cause=01, CPU PC=0x14.
REQ-038 RUN arg=100, halt_req 3 cycles after acceptance -> exactly 3 enabled cycles, stop_cause=11.
REQ-039 SET_BP 0x10, RUN 100 -> stops with cpu_pc=0x10, stop_cause=10; second RUN 1 -> PC=0x14, stop_cause=01.
REQ-040 DUMP with dump_ready toggling every other cycle -> 32 transfers, idx 0..31 in order, data matches register file, $0=0.
REQ-041 RUN arg=0 -> no cpu_run pulse, stop_cause=01; rst during DUMP at idx 7 -> dump_valid 0 next cycle, state IDLE.
REQ-042 Macro undefined: SET_BP 0x10 then RUN 100 -> no BP stop, stop_cause=01 after 100 cycles.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// mips_dbg_pkg -- shared types for the MIPS debug controller.
//   state_e      : controller FSM states (IDLE, RUN, DUMP_LD, DUMP_HS)
//   cmd_op_e     : command opcodes carried on cmd_op
//   stop_cause_e : reason the last run ended, reported on stop_cause
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DUMP_LD = 2'd2,
    ST_DUMP_HS = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_RUN    = 2'b00,
    OP_STEP   = 2'b01,
    OP_DUMP   = 2'b10,
    OP_SET_BP = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    SC_NONE  = 2'b00,
    SC_COUNT = 2'b01,
    SC_BP    = 2'b10,
    SC_HALT  = 2'b11
  } stop_cause_e;

  // Register-file address width (32-entry MIPS register file).
  localparam int IDX_W = 5;

endpackage

// File: rtl/mips_dbg_dump_seq.sv
// mips_dbg_dump_seq -- register-file readout sequencer.
// Walks idx 0..NREGS-1. In DUMP_LD the register at idx is read and captured
// into dump_data; in DUMP_HS dump_valid is held with stable idx/data until
// dump_ready. The top FSM owns the state register and follows 'done'.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   state            : current controller state from the top
//   start            : DUMP command accepted this cycle (rewinds idx)
//   rf_raddr/rf_rdata: combinational register-file read port
//   dump_valid/ready : readout handshake, dump_idx/dump_data payload
//   done             : handshake on the last register this cycle
module mips_dbg_dump_seq
  import mips_dbg_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  state_e           state,
  input  logic             start,
  output logic [IDX_W-1:0] rf_raddr,
  input  logic [31:0]      rf_rdata,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [IDX_W-1:0] dump_idx,
  output logic [31:0]      dump_data,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  logic [IDX_W-1:0] idx;
  logic             hs;

  assign hs       = dump_valid && dump_ready;
  assign done     = hs && (idx == LAST_IDX);
  assign rf_raddr = idx;
  assign dump_idx = idx;

  // NOTE: every register here is written with non-blocking assignments so all
  // flops sample the same pre-edge values, independent of statement order.
  // dump_data is a plain 32-bit register (not a memory), so it is cheap to
  // reset and keeps the bus at a known value out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
    end else if (start) begin
      idx <= '0;
    end else if (state == ST_DUMP_LD) begin
      dump_data  <= rf_rdata;
      dump_valid <= 1'b1;
    end else if (hs) begin
      dump_valid <= 1'b0;
      if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/mips_dbg_ctrl.sv
// mips_dbg_ctrl -- debug controller for a MIPS core.
// Accepts RUN/STEP/DUMP/SET_BP commands in IDLE, gates the CPU datapath with
// cpu_run for a counted number of cycles, and stops early on halt_req or a
// breakpoint match. DUMP streams the register file out via mips_dbg_dump_seq.
// Optional feature: define MIPS_DBG_BREAKPOINT_EN to build the PC breakpoint;
// without it SET_BP is a one-cycle no-op and stop_cause is never BP.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cmd_valid/ready/op/arg   : command handshake and payload
//   halt_req                 : single-cycle stop request during RUN
//   cpu_run, cpu_pc          : datapath enable, current program counter
//   rf_raddr, rf_rdata       : register-file read port
//   dump_valid/ready/idx/data: register dump stream
//   halted, stop_cause       : status
module mips_dbg_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic             halt_req,
  output logic             cpu_run,
  input  logic [31:0]      cpu_pc,
  output logic [4:0]       rf_raddr,
  input  logic [31:0]      rf_rdata,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [4:0]       dump_idx,
  output logic [31:0]      dump_data,
  output logic             halted,
  output logic [1:0]       stop_cause
);

  state_e           state;
  stop_cause_e      cause;
  cmd_op_e          op;
  logic [CNT_W-1:0] counter;
  logic             first_cycle;  // first RUN cycle: breakpoint is exempt
  logic             cmd_fire;
  logic             bp_hit;
  logic             dump_done;

  assign op         = cmd_op_e'(cmd_op);
  assign cmd_ready  = (state == ST_IDLE);
  assign halted     = (state == ST_IDLE);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign stop_cause = cause;

`ifdef MIPS_DBG_BREAKPOINT_EN
  logic        bp_armed;
  logic [31:0] bp_addr;

  // Skipping the first RUN cycle lets a run resume from the breakpoint PC.
  assign bp_hit = (state == ST_RUN) && bp_armed && (cpu_pc == bp_addr) && !first_cycle;

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_armed <= 1'b0;
      bp_addr  <= '0;
    end else if (cmd_fire && op == OP_SET_BP) begin
      bp_armed <= 1'b1;
      bp_addr  <= 32'(cmd_arg);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^cpu_pc;
  assign bp_hit    = 1'b0;
`endif

  // NOTE: cpu_run is deliberately combinational: a halt or breakpoint must
  // remove the enable in the very cycle it is seen, which a registered output
  // could only do one cycle late.
  assign cpu_run = (state == ST_RUN) && !halt_req && !bp_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      counter     <= '0;
      first_cycle <= 1'b0;
      cause       <= SC_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (op)
              OP_RUN: begin
                if (cmd_arg == '0) begin
                  cause <= SC_COUNT;
                end else begin
                  counter     <= cmd_arg;
                  first_cycle <= 1'b1;
                  state       <= ST_RUN;
                end
              end
              OP_STEP: begin
                counter     <= CNT_W'(1);
                first_cycle <= 1'b1;
                state       <= ST_RUN;
              end
              OP_DUMP: state <= ST_DUMP_LD;
              default: ;  // SET_BP completes here; its registers live above
            endcase
          end
        end
        ST_RUN: begin
          // Stop priority: HALT > BP > COUNT.
          if (halt_req) begin
            state <= ST_IDLE;
            cause <= SC_HALT;
          end else if (bp_hit) begin
            state <= ST_IDLE;
            cause <= SC_BP;
          end else if (counter == CNT_W'(1)) begin
            counter <= '0;
            state   <= ST_IDLE;
            cause   <= SC_COUNT;
          end else begin
            counter     <= counter - CNT_W'(1);
            first_cycle <= 1'b0;
          end
        end
        ST_DUMP_LD: state <= ST_DUMP_HS;
        ST_DUMP_HS: begin
          if (dump_done)       state <= ST_IDLE;
          else if (dump_valid && dump_ready) state <= ST_DUMP_LD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mips_dbg_dump_seq #(.NREGS(NREGS)) u_dump_seq (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .start     (cmd_fire && op == OP_DUMP),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_idx  (dump_idx),
    .dump_data (dump_data),
    .done      (dump_done)
  );

endmodule

// File: tb/tb_mips_dbg_ctrl.sv
// tb_mips_dbg_ctrl -- self-checking bench for mips_dbg_ctrl.
// A small CPU model (PC advancing by 4 while cpu_run) and a register-file
// array sit around the DUT; run outcomes come from a cycle-stepping model of
// the command rules, dump transfers from the bench's own register array.
// Honours MIPS_DBG_BREAKPOINT_EN like the design.
module tb_mips_dbg_ctrl;

  localparam int CNT_W = 32;
`ifdef MIPS_DBG_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  localparam logic [1:0] C_RUN = 2'b00, C_STEP = 2'b01, C_DUMP = 2'b10, C_SETBP = 2'b11;
  localparam logic [1:0] S_NONE = 2'b00, S_COUNT = 2'b01, S_BP = 2'b10, S_HALT = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;
  logic             halt_req;
  logic             cpu_run;
  logic [31:0]      cpu_pc;
  logic [4:0]       rf_raddr;
  logic [31:0]      rf_rdata;
  logic             dump_valid;
  logic             dump_ready;
  logic [4:0]       dump_idx;
  logic [31:0]      dump_data;
  logic             halted;
  logic [1:0]       stop_cause;

  int errors = 0;
  int checks = 0;

  // CPU and register-file models
  logic [31:0] pc;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic [31:0] rf [32];

  // Reference state tracked by the bench
  logic [1:0]  exp_cause;
  bit          bp_armed_m;
  logic [31:0] bp_addr_m;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pc_load)      pc <= pc_load_val;
    else if (cpu_run) pc <= pc + 32'd4;
  end

  assign cpu_pc   = pc;
  assign rf_rdata = rf[rf_raddr];

  mips_dbg_ctrl #(.CNT_W(CNT_W), .NREGS(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .halt_req(halt_req), .cpu_run(cpu_run), .cpu_pc(cpu_pc),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .halted(halted), .stop_cause(stop_cause)
  );

  // Steps a run cycle by cycle: in RUN cycle k (1-based) halt wins, then the
  // breakpoint (not on k==1), else the CPU advances; after n cycles COUNT.
  function automatic void model_run(input int n, input int halt_at, input logic [31:0] pc0,
                                    output int en, output logic [1:0] cause, output logic [31:0] pc_end);
    logic [31:0] p;
    p = pc0; en = 0; cause = S_COUNT;
    for (int k = 1; k <= n; k++) begin
      if (k == halt_at) begin cause = S_HALT; break; end
      if (BP_EN && bp_armed_m && k > 1 && p == bp_addr_m) begin cause = S_BP; break; end
      p  = p + 32'd4;
      en = en + 1;
    end
    pc_end = p;
  endfunction

  task automatic set_pc(input logic [31:0] v);
    @(negedge clk);
    pc_load = 1'b1; pc_load_val = v;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  // Offers one command; returns at the negedge of the cycle after acceptance.
  task automatic send_cmd(input logic [1:0] op, input logic [CNT_W-1:0] arg, input string name);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s cmd_ready: got %b want 1", name, cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_run(input logic [1:0] op, input logic [CNT_W-1:0] arg, input int halt_at, input string name);
    int n, exp_en, en;
    logic [1:0] c_exp;
    logic [31:0] pc_exp;
    bit done;
    n = (op == C_STEP) ? 1 : int'(arg);
    model_run(n, halt_at, pc, exp_en, c_exp, pc_exp);
    send_cmd(op, arg, name);
    en = 0; done = 1'b0;
    for (int k = 1; k <= n + 4; k++) begin
      halt_req = (k == halt_at);
      #1;
      if (halted) begin done = 1'b1; break; end
      if (cpu_run) en++;
      @(negedge clk);
    end
    halt_req = 1'b0;
    exp_cause = c_exp;
    checks++;
    if (!done) begin errors++; $display("FAIL %s timeout: halted never returned within %0d cycles", name, n + 4); end
    checks++;
    if (en !== exp_en) begin errors++; $display("FAIL %s enabled cycles: got %0d want %0d", name, en, exp_en); end
    checks++;
    if (stop_cause !== c_exp) begin errors++; $display("FAIL %s stop_cause: got %b want %b", name, stop_cause, c_exp); end
    checks++;
    if (pc !== pc_exp) begin errors++; $display("FAIL %s pc: got %h want %h", name, pc, pc_exp); end
    checks++;
    if (cpu_run !== 1'b0) begin errors++; $display("FAIL %s cpu_run after stop: got %b want 0", name, cpu_run); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({halted, cmd_ready, cpu_run, dump_valid} !== 4'b1100) begin
      errors++; $display("FAIL reset flags {halted,ready,run,valid}: got %b want 1100", {halted, cmd_ready, cpu_run, dump_valid});
    end
    checks++;
    if (stop_cause !== S_NONE) begin errors++; $display("FAIL reset stop_cause: got %b want 00", stop_cause); end
    checks++;
    if (dump_data !== 32'd0 || dump_idx !== 5'd0) begin
      errors++; $display("FAIL reset dump regs: got idx %0d data %h want 0/0", dump_idx, dump_data);
    end
    rst = 1'b0;
    exp_cause = S_NONE; bp_armed_m = 1'b0; bp_addr_m = '0;
  endtask

  task automatic test_run_count();
    set_pc(32'h0);
    do_run(C_RUN, 5, 0, "run5");
    for (int i = 0; i < 4; i++) begin
      set_pc($urandom & 32'hFFFF_FFFC);
      do_run(C_RUN, CNT_W'($urandom_range(1, 20)), 0, "run_rand");
    end
  endtask

  task automatic test_step();
    set_pc(32'h40);
    do_run(C_STEP, $urandom, 0, "step");
    do_run(C_STEP, 32'd0, 0, "step_arg0");
  endtask

  task automatic test_halt();
    int n;
    set_pc(32'h0);
    do_run(C_RUN, 100, 4, "halt_run100");
    do_run(C_RUN, 4, 4, "halt_vs_count");
    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(2, 16);
      do_run(C_RUN, CNT_W'(n), $urandom_range(1, n), "halt_rand");
    end
    // halt_req in IDLE must have no effect
    @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b1 || stop_cause !== exp_cause) begin
      errors++; $display("FAIL halt_idle: got halted %b cause %b want 1/%b", halted, stop_cause, exp_cause);
    end
  endtask

  task automatic test_run_zero();
    do_run(C_RUN, 32'd0, 0, "run0");
  endtask

  task automatic test_breakpoint();
    set_pc(32'h0);
    send_cmd(C_SETBP, 32'h10, "setbp");
    if (BP_EN) begin bp_armed_m = 1'b1; bp_addr_m = 32'h10; end
    #1;
    checks++;
    if (halted !== 1'b1 || cmd_ready !== 1'b1 || stop_cause !== exp_cause) begin
      errors++; $display("FAIL setbp one-cycle: got halted %b ready %b cause %b want 1/1/%b", halted, cmd_ready, stop_cause, exp_cause);
    end
    do_run(C_RUN, 100, 0, "bp_run100");
    do_run(C_RUN, 1, 0, "bp_resume1");
    set_pc(32'h0);
    do_run(C_RUN, 100, 5, "bp_vs_halt");
    set_pc(32'h0);
    do_run(C_RUN, 5, 0, "bp_vs_count");
    do_run(C_RUN, 3, 0, "bp_resume3");
  endtask

  task automatic do_dump(input bit rand_ready, input string name);
    int cnt, first;
    bit stall, done;
    logic [4:0]  s_idx;
    logic [31:0] s_data, r0;
    logic [1:0]  cause_before;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'd0;
    cause_before = exp_cause;
    send_cmd(C_DUMP, $urandom, name);
    cnt = 0; first = -1; stall = 1'b0; done = 1'b0; r0 = 32'hFFFF_FFFF;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      dump_ready = rand_ready ? 1'($urandom) : 1'(cyc % 2);
      #1;
      if (halted) begin done = 1'b1; break; end
      checks++;
      if (cpu_run !== 1'b0) begin errors++; $display("FAIL %s cpu_run in dump: got %b want 0", name, cpu_run); end
      if (dump_valid) begin
        if (first < 0) first = cyc;
        if (stall) begin
          checks++;
          if (dump_idx !== s_idx || dump_data !== s_data) begin
            errors++; $display("FAIL %s stall stability: got %0d/%h want %0d/%h", name, dump_idx, dump_data, s_idx, s_data);
          end
        end
        if (dump_ready) begin
          checks++;
          if (cnt > 31 || dump_idx !== 5'(cnt) || dump_data !== rf[cnt[4:0]]) begin
            errors++; $display("FAIL %s transfer %0d: got idx %0d data %h want idx %0d data %h",
                               name, cnt, dump_idx, dump_data, cnt, rf[cnt[4:0]]);
          end
          if (cnt == 0) r0 = dump_data;
          cnt++; stall = 1'b0;
        end else begin
          stall = 1'b1; s_idx = dump_idx; s_data = dump_data;
        end
      end
      @(negedge clk);
    end
    dump_ready = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL %s timeout: dump did not return to IDLE", name); end
    checks++;
    if (cnt !== 32) begin errors++; $display("FAIL %s transfer count: got %0d want 32", name, cnt); end
    checks++;
    if (first !== 2) begin errors++; $display("FAIL %s first valid cycle: got %0d want 2", name, first); end
    checks++;
    if (r0 !== 32'd0) begin errors++; $display("FAIL %s reg0: got %h want 0", name, r0); end
    checks++;
    if (stop_cause !== cause_before) begin errors++; $display("FAIL %s stop_cause: got %b want %b", name, stop_cause, cause_before); end
  endtask

  task automatic test_dump();
    do_dump(1'b0, "dump_toggle");
    do_dump(1'b1, "dump_random");
  endtask

  task automatic test_reset_mid_dump();
    bit seen;
    send_cmd(C_DUMP, '0, "rst_dump cmd");
    seen = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      dump_ready = 1'b0;
      #1;
      if (dump_valid && dump_idx == 5'd7) begin seen = 1'b1; break; end
      if (dump_valid) dump_ready = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_dump reach idx7: not seen within budget"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_cause = S_NONE; bp_armed_m = 1'b0;
    checks++;
    if (dump_valid !== 1'b0 || halted !== 1'b1 || dump_idx !== 5'd0) begin
      errors++; $display("FAIL rst_dump after reset: got valid %b halted %b idx %0d want 0/1/0", dump_valid, halted, dump_idx);
    end
    checks++;
    if (stop_cause !== S_NONE) begin errors++; $display("FAIL rst_dump stop_cause: got %b want 00", stop_cause); end
  endtask

  task automatic test_reset_mid_run();
    set_pc(32'h100);
    send_cmd(C_RUN, 50, "rst_run cmd");
    repeat (3) @(negedge clk);
    rst = 1'b1;  // cpu_run still high this cycle: fourth CPU step
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (cpu_run !== 1'b0 || halted !== 1'b1) begin
      errors++; $display("FAIL rst_run after reset: got run %b halted %b want 0/1", cpu_run, halted);
    end
    checks++;
    if (pc !== 32'h110) begin errors++; $display("FAIL rst_run pc at reset: got %h want 00000110", pc); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (pc !== 32'h110) begin errors++; $display("FAIL rst_run pc frozen: got %h want 00000110", pc); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0; halt_req = 1'b0;
    dump_ready = 1'b0; pc_load = 1'b0; pc_load_val = '0; pc = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    test_reset();
    test_run_count();
    test_step();
    test_halt();
    test_run_zero();
    test_breakpoint();
    test_dump();
    test_reset_mid_dump();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
